// File: rtl/regfile_wb_arbiter_pkg.sv
// rv_pkg: shared register-file constants used by the writeback arbiter slice.
//   XLEN   - data width
//   AW     - register address width
//   NREG   - number of architectural registers
//   REG_X0 - index of the hardwired-zero register
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned NREG   = 1 << AW;
    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: bundle between the writeback sources / decode stage
// and the register-file writeback arbiter.
//   req/req_addr/req_data/ack      - per-source writeback handshake (flattened)
//   rsv_en/rsv_addr                - destination reservation at issue
//   rs1_addr/rs2_addr/hazard1/2    - decode-stage busy lookups
//   wb_en/wb_addr/wb_data          - registered register-file write port
// slave: the arbiter. master: the units around it.
interface regfile_wb_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5
);

    logic [N_REQ-1:0]      req;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ*XLEN-1:0] req_data;
    logic [N_REQ-1:0]      ack;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic [AW-1:0]         rs1_addr;
    logic [AW-1:0]         rs2_addr;
    logic                  hazard1;
    logic                  hazard2;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [XLEN-1:0]       wb_data;

    modport slave (
        input  req, req_addr, req_data, rsv_en, rsv_addr, rs1_addr, rs2_addr,
        output ack, hazard1, hazard2, wb_en, wb_addr, wb_data
    );

    modport master (
        output req, req_addr, req_data, rsv_en, rsv_addr, rs1_addr, rs2_addr,
        input  ack, hazard1, hazard2, wb_en, wb_addr, wb_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   ptr     - index where the search starts (always < N)
//   gnt     - one-hot grant, zero when no request
//   gnt_idx - index of the granted bit (0 when no request)
module rr_arbiter #(
    parameter  int unsigned N  = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        logic [PW-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N, so one conditional subtract is enough to wrap
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between
// N_REQ writeback sources with round-robin arbitration, registers the chosen
// write, and keeps a busy scoreboard for decode-stage RAW hazard checks.
//   CLK - clock, all state on posedge
//   RST - synchronous reset, active-low
//   bus - handshake, reservation, hazard and writeback signals (slave side)
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter  int unsigned N_REQ = 3,
    parameter  int unsigned XLEN  = rv_pkg::XLEN,
    parameter  int unsigned AW    = rv_pkg::AW,
    localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int unsigned NR    = 1 << AW
) (
    input logic                 CLK,
    input logic                 RST,
    regfile_wb_arbiter_if.slave bus
);

    logic [PW-1:0]    ptr;
    logic [NR-1:0]    busy;
    logic [NR-1:0]    busy_nxt;
    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_idx;
    logic             grant;
    logic [AW-1:0]    sel_addr;
    logic [XLEN-1:0]  sel_data;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Nothing is granted while reset is held, so pending requests are dropped.
    assign grant   = RST && (|gnt);
    assign bus.ack = RST ? gnt : '0;

    // One-hot AND-OR mux of the granted source's address and data
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sel_addr = sel_addr | (bus.req_addr[i*AW +: AW] & {AW{gnt[i]}});
            sel_data = sel_data | (bus.req_data[i*XLEN +: XLEN] & {XLEN{gnt[i]}});
        end
    end

    // Clear is applied before set so a same-edge reserve of the retiring
    // register leaves it busy for the new producer.
    always_comb begin
        busy_nxt = busy;
        if (grant) busy_nxt[sel_addr] = 1'b0;
        if (bus.rsv_en) busy_nxt[bus.rsv_addr] = 1'b1;
        busy_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr         <= '0;
            busy        <= '0;
            bus.wb_en   <= 1'b0;
            bus.wb_addr <= '0;
            bus.wb_data <= '0;
        end else begin
            busy <= busy_nxt;
            if (grant) begin
                ptr         <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                bus.wb_en   <= (sel_addr != AW'(REG_X0));
                bus.wb_addr <= sel_addr;
                bus.wb_data <= sel_data;
            end else begin
                bus.wb_en <= 1'b0;
            end
        end
    end

    // Lookups see only the state from the last edge; no bypass from wb_*.
    assign bus.hazard1 = busy[bus.rs1_addr];
    assign bus.hazard2 = busy[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    regfile_wb_arbiter_if #(.N_REQ(3), .XLEN(32), .AW(5)) bus ();

    regfile_wb_arbiter #(.N_REQ(3), .XLEN(32), .AW(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_src(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_addr[i*5 +: 5]   = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    // Handshake monitor: a request not yet acked must still be present.
    logic       hs_en = 1'b0;
    logic [2:0] prev_req = '0;
    logic [2:0] prev_ack = '0;
    always @(negedge CLK) begin
        if (hs_en && RST) begin
            for (int i = 0; i < 3; i++)
                if (prev_req[i] && !prev_ack[i])
                    chk("handshake_hold", {63'd0, bus.req[i]}, 64'd1);
        end
        prev_req = bus.req;
        prev_ack = bus.ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  exp_seq [6];
        int          exp_idx [6];
        logic [2:0]  pend;
        logic [4:0]  raddr [3];
        logic [31:0] rdata [3];
        int          wait_c [3];
        int          acks [3];
        int          mptr;
        int          eidx;
        logic [2:0]  e;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        got;

        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_idx = '{0, 1, 2, 0, 1, 2};

        bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;

        // Reset with all sources requesting
        RST = 1'b0;
        for (int i = 0; i < 3; i++) set_src(i, 5'(i + 1), 32'hA0 + i);
        bus.req = 3'b111;
        bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd2;
        #1;
        chk("rst_ack0", 64'(bus.ack), 64'd0);
        tick();
        chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
        chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_haz1", 64'(bus.hazard1), 64'd0);
        chk("rst_haz2", 64'(bus.hazard2), 64'd0);
        chk("rst_ack1", 64'(bus.ack), 64'd0);
        tick();
        chk("rst_ack2", 64'(bus.ack), 64'd0);
        chk("rst_wb_en2", 64'(bus.wb_en), 64'd0);
        RST = 1'b1;

        // Round robin with all three requesting
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_ack", 64'(bus.ack), 64'(exp_seq[k]));
            tick();
            chk("rr_wb_en", 64'(bus.wb_en), 64'd1);
            chk("rr_wb_addr", 64'(bus.wb_addr), 64'(exp_idx[k] + 1));
            chk("rr_wb_data", 64'(bus.wb_data), 64'(32'hA0 + exp_idx[k]));
        end

        // Idle: wb_en drops, address/data hold
        bus.req = '0;
        #1;
        chk("idle_ack", 64'(bus.ack), 64'd0);
        tick();
        chk("idle_wb_en", 64'(bus.wb_en), 64'd0);
        chk("idle_wb_addr", 64'(bus.wb_addr), 64'd3);
        chk("idle_wb_data", 64'(bus.wb_data), 64'hA2);

        // x0 write is acked but never written
        set_src(1, 5'd0, 32'hDEADBEEF);
        bus.req = 3'b010;
        #1;
        chk("x0_ack", 64'(bus.ack), 64'b010);
        tick();
        bus.req = '0;
        chk("x0_wb_en", 64'(bus.wb_en), 64'd0);
        set_src(1, 5'd5, 32'h12345678);
        bus.req = 3'b010;
        #1;
        chk("a5_ack", 64'(bus.ack), 64'b010);
        tick();
        bus.req = '0;
        chk("a5_wb_en", 64'(bus.wb_en), 64'd1);
        chk("a5_wb_addr", 64'(bus.wb_addr), 64'd5);
        chk("a5_wb_data", 64'(bus.wb_data), 64'h12345678);

        // Scoreboard: reserve 7, then retire it
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd3;
        #1;
        chk("sb_haz1_before", 64'(bus.hazard1), 64'd0);
        tick();
        bus.rsv_en = 1'b0;
        #1;
        chk("sb_haz1_set", 64'(bus.hazard1), 64'd1);
        chk("sb_haz2_clear", 64'(bus.hazard2), 64'd0);
        set_src(0, 5'd7, 32'h77);
        bus.req = 3'b001;
        #1;
        chk("sb_grant7_ack", 64'(bus.ack), 64'b001);
        chk("sb_haz1_same_cycle", 64'(bus.hazard1), 64'd1);
        tick();
        bus.req = '0;
        #1;
        chk("sb_haz1_cleared", 64'(bus.hazard1), 64'd0);

        // Same-edge reserve and retire of 7: set wins
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
        tick();
        #1;
        chk("sb_haz1_reset7", 64'(bus.hazard1), 64'd1);
        bus.req = 3'b001;
        #1;
        chk("sb_both_ack", 64'(bus.ack), 64'b001);
        tick();
        bus.rsv_en = 1'b0; bus.req = '0;
        #1;
        chk("sb_set_wins", 64'(bus.hazard1), 64'd1);
        bus.req = 3'b001;
        tick();
        bus.req = '0;
        #1;
        chk("sb_final_clear", 64'(bus.hazard1), 64'd0);

        // Reserving x0 is ignored
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0; bus.rs1_addr = 5'd0;
        tick();
        bus.rsv_en = 1'b0;
        #1;
        chk("sb_x0_never_busy", 64'(bus.hazard1), 64'd0);

        // Fairness: src0 constant, src2 joins at cycle 3
        set_src(0, 5'd10, 32'h100); set_src(2, 5'd12, 32'h300);
        bus.req = 3'b001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fair_src0_ack", 64'(bus.ack), 64'b001);
            tick();
        end
        bus.req = 3'b101;
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            #1;
            if (bus.ack[2]) got = 1'b1;
            tick();
            if (!got && bus.ack[0] == 1'b0) bus.req[0] = 1'b1;
        end
        chk("fair_src2_within_n", 64'(got), 64'd1);
        bus.req = '0;
        tick();

        // Random contention with a reference round-robin model
        mptr = 0;
        pend = '0;
        for (int i = 0; i < 3; i++) begin wait_c[i] = 0; acks[i] = 0; end
        hs_en = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    raddr[i] = 5'($urandom_range(0, 31));
                    rdata[i] = $urandom;
                    set_src(i, raddr[i], rdata[i]);
                end
            end
            bus.req = pend;
            #1;
            e = '0; eidx = 0;
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (mptr + k) % 3;
                if (pend[idx] && e == 3'b000) begin e[idx] = 1'b1; eidx = idx; end
            end
            chk("rand_ack", 64'(bus.ack), 64'(e));
            exp_en = 1'b0;
            if (e != 3'b000) begin
                mptr     = (eidx + 1) % 3;
                exp_en   = (raddr[eidx] != 5'd0);
                exp_addr = raddr[eidx];
                exp_data = rdata[eidx];
                acks[eidx]++;
                pend[eidx] = 1'b0;
                wait_c[eidx] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    wait_c[i]++;
                    chk("rand_no_starve", 64'(wait_c[i] < 3), 64'd1);
                end
            end
            tick();
            if (e != 3'b000 || cyc > 0) begin
                chk("rand_wb_en", 64'(bus.wb_en), 64'(exp_en));
                if (e != 3'b000) begin
                    chk("rand_wb_addr", 64'(bus.wb_addr), 64'(exp_addr));
                    chk("rand_wb_data", 64'(bus.wb_data), 64'(exp_data));
                end
            end
        end
        hs_en = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 3; i++) chk("rand_cov_src", 64'(acks[i] > 0), 64'd1);
        tick();

        // Mid-operation reset with a grant in flight and busy[9] set
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9; bus.rs1_addr = 5'd9;
        set_src(1, 5'd4, 32'h44);
        bus.req = 3'b010;
        #1;
        chk("mid_pre_ack", 64'(bus.ack), 64'b010);
        tick();
        bus.rsv_en = 1'b0;
        RST = 1'b0;
        #1;
        chk("mid_rst_ack", 64'(bus.ack), 64'd0);
        chk("mid_haz1_busy", 64'(bus.hazard1), 64'd1);
        chk("mid_inflight_wb_en", 64'(bus.wb_en), 64'd1);
        chk("mid_inflight_wb_addr", 64'(bus.wb_addr), 64'd4);
        tick();
        RST = 1'b1;
        bus.req = '0;
        #1;
        chk("mid_busy9_cleared", 64'(bus.hazard1), 64'd0);
        chk("mid_wb_en_low", 64'(bus.wb_en), 64'd0);
        chk("mid_no_ack", 64'(bus.ack), 64'd0);
        bus.req = 3'b111;
        #1;
        chk("mid_ptr_reset", 64'(bus.ack), 64'b001);
        tick();
        bus.req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
